axis_rr_arbiter: RTL and testbench
==================================

# axis_rr_arbiter

Packet-level round-robin arbiter that shares one AXI-stream datapath, such as a skid-buffered systolic-array input lane, between N upstream requesters. It grants one input at a time, forwards that input's beats until `s_last` and registers the output. It tags each beat with the source index so the downstream logic can route results back to the requester.

## Interface
- `N`, 4: number of requesting inputs, ≥2.
- `WIDTH`, 8: data width per beat.
- `ID_W`, `$clog2(N)`: derived width of the source tag; not overridden.

- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `s_valid` in N: per-input valid.
- `s_ready` out N: per-input ready; at most one bit high at a time.
- `s_data` in N×WIDTH: per-input data, packed as `[N-1:0][WIDTH-1:0]`.
- `s_last` in N: per-input end-of-packet.
- `m_valid` out 1: output valid (registered).
- `m_ready` in 1: downstream ready.
- `m_data` out WIDTH: output data (registered).
- `m_last` out 1: output end-of-packet (registered).
- `m_id` out ID_W: index of the input that sourced the current beat (registered).

## Operation
- Two-state FSM:
  - IDLE: no grant is held.
  - BUSY: grant `g` is held.
- IDLE → BUSY when any `s_valid` is high.
  - `g` = the first asserted input searching upward from `ptr`, wrapping modulo N.
  - The arbitration cycle accepts no beat: one-cycle bubble per packet.
- BUSY:
  - `s_ready[g] = !m_valid || m_ready`.
  - All other `s_ready` bits are 0.
  - A beat is accepted when `s_valid[g] && s_ready[g]`.
  - On acceptance, register `m_data ← s_data[g]`, `m_last ← s_last[g]`, `m_id ← g`, `m_valid ← 1`.
- BUSY → IDLE on an accepted beat with `s_last[g]=1`. On that transition `ptr ← (g+1) mod N`, wrapping from N-1 to 0.
- Output register:
  - `m_valid` clears when `m_ready` is high and no new beat is accepted in the same cycle.
  - `m_data`, `m_last` and `m_id` hold their value while `m_valid && !m_ready`.
- A grant is never revoked mid-packet, regardless of other inputs or a deasserted `s_valid[g]`. An idle granted input stalls the arbiter; this is intended.
- `s_valid` on a non-granted input is ignored and must be held by its source (AXI rule). The arbiter consumes nothing from that input.

## Timing
- Reset values: `m_valid=0`, `m_data=0`, `m_last=0`, `m_id=0`, `ptr=0`, state IDLE.
- `s_ready` is combinational from state and `m_ready`. It is 0 during reset and in IDLE.
- Latency: a beat accepted at edge t is visible on `m_*` after edge t. Throughput is 1 beat/cycle within a packet.
- Cost per packet: 1 arbitration cycle in IDLE between packets, so an N-input saturated load gets L/(L+1) of the bandwidth for packet length L.
- Single-beat packet (`s_last` on first beat): IDLE → BUSY → IDLE. The next grant is decided the cycle after.
- Simultaneous `m_ready` and a new accept: the output register is overwritten with no bubble.
- All inputs idle in IDLE: FSM stays in IDLE and `ptr` is unchanged.
- `rstn` low mid-packet: state, output register and `ptr` clear at the next edge. The partial packet is dropped and no `m_last` is emitted.

## Configuration
- `AXIS_ARB_PRIO0_EN`
  - Defined: input 0 is strict-priority. In IDLE, if `s_valid[0]` is high, `g=0` regardless of `ptr`, and `ptr` is not updated after an input-0 packet. The other inputs rotate round-robin among themselves.
  - Undefined: pure round-robin across all N inputs, as above.

## Structure
- Shared package `axis_arb_pkg`:
  - state enum `{IDLE, BUSY}`.
  - `ID_W` helper function (`$clog2` with a minimum of 1).
- Sub-module `rr_pick #(N)`: combinational rotate-and-priority-encode.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `gnt_idx`, `gnt_any`.
  - The priority override is applied outside it.

## Test plan
- N=4, all inputs hold 3-beat packets continuously, `m_ready=1` → grant order 0,1,2,3,0, `m_id` matches, one idle cycle between packets.
- Only input 2 valid with a 1-beat packet, `data=0xA5` → `m_data=0xA5`, `m_id=2`, `m_last=1` two cycles after `s_valid`, then `ptr=3`.
- Mid-packet on input 1, toggle `m_ready` 1,0,0,1 → output held stable while stalled, no beat lost or duplicated, `s_ready[1]` tracks `m_ready`.
- Input 3 granted, inputs 0 and 1 then request → after input 3's `s_last`, input 0 wins (wrap), then input 1.
- Assert `rstn=0` for one cycle mid-packet → `m_valid=0`, `ptr=0`, state IDLE. After release, a new request is granted normally.
- With `AXIS_ARB_PRIO0_EN`, inputs 0 and 2 both request continuously → input 0 is granted every arbitration and `ptr` is unchanged.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: state encoding and width helper shared by the AXI-stream
// round-robin arbiter and its pick sub-module.
package axis_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY
    } state_t;

    // Source-tag width; never narrower than one bit so ports stay legal.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-and-priority-encode. Returns the first
// asserted request found searching upward from ptr, wrapping modulo N.
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = id_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [ID_W-1:0] idx;

    // Scan from farthest to nearest so the candidate closest to ptr is written last and wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ID_W'((int'(ptr) + i) % N);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin arbiter sharing one AXI-stream
// output between N requesters, with a registered output stage and a source
// tag (m_id) on every beat.
// Optional build macro AXIS_ARB_PRIO0_EN: input 0 becomes strict priority and
// its packets do not advance the round-robin pointer.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant held; this cycle picks the next grant (no beat moves)
// BUSY  | grant g held; beats of input g flow until its s_last is taken
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = id_w(N)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N-1:0]              s_valid,
    output logic [N-1:0]              s_ready,
    input  logic [N-1:0][WIDTH-1:0]   s_data,
    input  logic [N-1:0]              s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [WIDTH-1:0]          m_data,
    output logic                      m_last,
    output logic [ID_W-1:0]           m_id
);

    state_t          state;
    logic [ID_W-1:0] g;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] pick_idx;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] g_succ;
    logic            pick_any;
    logic            accept;
    logic            pkt_done;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req     (s_valid),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Apply the optional input-0 override on top of the round-robin pick.
    always_comb begin
`ifdef AXIS_ARB_PRIO0_EN
        grant_idx = s_valid[0] ? '0 : pick_idx;
`else
        grant_idx = pick_idx;
`endif
    end

    // Only the granted input sees ready, and only when the output stage can take a beat.
    always_comb begin
        s_ready = '0;
        if (rstn && (state == BUSY) && (!m_valid || m_ready)) begin
            s_ready[g] = 1'b1;
        end
    end

    assign accept   = s_valid[g] & s_ready[g];
    assign pkt_done = accept & s_last[g];
    assign g_succ   = (g == ID_W'(N - 1)) ? '0 : g + 1'b1;

    // Grant FSM and round-robin pointer; a grant is released only by its own s_last.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state <= BUSY;
                        g     <= grant_idx;
                    end
                end
                BUSY: begin
                    if (pkt_done) begin
                        state <= IDLE;
`ifdef AXIS_ARB_PRIO0_EN
                        if (g != '0) begin
                            ptr <= g_succ;
                        end
`else
                        ptr <= g_succ;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: load on accept, drain on m_ready, hold while stalled.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_id    <= '0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= s_data[g];
            m_last  <= s_last[g];
            m_id    <= g;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed stimulus for axis_rr_arbiter with a
// packet-level behavioural model compared every cycle, plus literal
// expectations for grant order, bubble spacing, stalls and reset.
module tb_axis_rr_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = 2;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic [N-1:0]            s_valid = '0;
    logic [N-1:0]            s_ready;
    logic [N-1:0][WIDTH-1:0] s_data = '0;
    logic [N-1:0]            s_last = '0;
    logic                    m_valid;
    logic                    m_ready = 1'b1;
    logic [WIDTH-1:0]        m_data;
    logic                    m_last;
    logic [ID_W-1:0]         m_id;

    axis_rr_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_id    (m_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- packet sources ----------------
    bit           en   [N];
    int           len  [N];
    int           pkts [N];
    int           base [N];
    int           bc   [N];
    int           tot  [N];
    logic [N-1:0] hs = '0;

    initial begin
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b0; len[i] = 1; pkts[i] = 0; base[i] = 0; bc[i] = 0; tot[i] = 0;
        end
    end

    always @(negedge clk) hs = s_valid & s_ready;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (!rstn) begin
                bc[i] = 0;
            end else if (hs[i]) begin
                tot[i]++;
                if (bc[i] == len[i] - 1) begin
                    bc[i] = 0;
                    pkts[i]--;
                end else begin
                    bc[i]++;
                end
            end
            s_valid[i] = en[i] && (pkts[i] > 0);
            s_data[i]  = WIDTH'(base[i] + tot[i]);
            s_last[i]  = (bc[i] == len[i] - 1);
        end
    end

    // ---------------- behavioural model ----------------
    bit         live = 1'b0;
    bit         busy = 1'b0;
    int         g_m = 0;
    int         ptr_m = 0;
    bit         ev = 1'b0;
    logic [7:0] ed = '0;
    bit         el = 1'b0;
    int         eid = 0;

    function automatic int choose(input logic [N-1:0] v, input int p);
`ifdef AXIS_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic bit moves_ptr(input int gi);
`ifdef AXIS_ARB_PRIO0_EN
        return gi != 0;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        bit acc;
        int gn;
        if (!rstn) begin
            live = 1'b1; busy = 1'b0; g_m = 0; ptr_m = 0;
            ev = 1'b0; ed = '0; el = 1'b0; eid = 0;
        end else begin
            acc = busy && (!ev || m_ready) && s_valid[g_m];
            if (acc) begin
                ev = 1'b1; ed = s_data[g_m]; el = s_last[g_m]; eid = g_m;
            end else if (m_ready) begin
                ev = 1'b0;
            end
            if (!busy) begin
                gn = choose(s_valid, ptr_m);
                if (gn >= 0) begin
                    busy = 1'b1;
                    g_m  = gn;
                end
            end else if (acc && s_last[g_m]) begin
                busy = 1'b0;
                if (moves_ptr(g_m)) ptr_m = (g_m + 1) % N;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [N-1:0] er;
        if (live) begin
            er = '0;
            if (rstn && busy && (!ev || m_ready)) er[g_m] = 1'b1;
            chk("m_valid", 32'(m_valid), 32'(ev));
            chk("m_data",  32'(m_data),  32'(ed));
            chk("m_last",  32'(m_last),  32'(el));
            chk("m_id",    32'(m_id),    32'(eid));
            chk("s_ready", 32'(s_ready), 32'(er));
            chk("ptr",     32'(dut.ptr), 32'(ptr_m));
            chk("state",   32'(dut.state), 32'(busy));
        end
    end

    // ---------------- output monitor ----------------
    int lasts[$];
    int bdata[$];
    int bid[$];
    bit vq[$];
    bit rec = 1'b0;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            bdata.push_back(int'(m_data));
            bid.push_back(int'(m_id));
            if (m_last) lasts.push_back(int'(m_id));
        end
        if (rec) vq.push_back(m_valid);
    end

    task automatic clear_q();
        lasts.delete(); bdata.delete(); bid.delete(); vq.delete();
    endtask

    task automatic cfg(input int i, input int e, input int l, input int p, input int b);
        en[i] = (e != 0); len[i] = l; pkts[i] = p; base[i] = b; bc[i] = 0; tot[i] = 0;
    endtask

    function automatic bit drained();
        bit d;
        d = !busy && !ev;
        for (int i = 0; i < N; i++) if (pkts[i] > 0) d = 1'b0;
        return d;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (!drained() && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk(name, 32'(k < budget), 32'd1);
    endtask

    task automatic wait_id_valid(input string name, input int id, input int budget);
        int k;
        k = 0;
        while (!(m_valid && int'(m_id) == id) && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk(name, 32'(k < budget), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int e1 [5];
        int bad;
        int f;
        int k;
        e1 = '{0, 1, 2, 3, 0};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_id",    32'(m_id),    32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_ptr",     32'(dut.ptr), 32'd0);
        #1 rstn = 1'b1;

        // all four inputs with 3-beat packets, m_ready high
        clear_q();
        rec = 1'b1;
        for (int i = 0; i < N; i++) cfg(i, 1, 3, 2, i * 64);
        wait_drain("t1_drain", 300);
        rec = 1'b0;
        chk("t1_npkts", 32'(lasts.size()), 32'd8);
        for (int i = 0; i < 5; i++)
            chk("t1_order", (lasts.size() > i) ? 32'(lasts[i]) : 32'hFFFF_FFFF, 32'(e1[i]));
        f = 0;
        while (f < vq.size() && !vq[f]) f++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (f + i >= vq.size()) bad++;
            else if (vq[f + i] != ((i % 4) != 3)) bad++;
        end
        chk("t1_bubble", 32'(bad), 32'd0);
        chk("t1_ptr", 32'(dut.ptr), 32'd0);

        // single-beat packet on input 2
        clear_q();
        cfg(2, 1, 1, 1, 8'hA5);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t2_valid", 32'(m_valid), 32'd1);
        chk("t2_data",  32'(m_data),  32'hA5);
        chk("t2_id",    32'(m_id),    32'd2);
        chk("t2_last",  32'(m_last),  32'd1);
        chk("t2_ptr",   32'(dut.ptr), 32'd3);
        #1;
        wait_drain("t2_drain", 50);

        // m_ready toggles mid-packet on input 1
        clear_q();
        cfg(1, 1, 4, 1, 8'h10);
        wait_id_valid("t3_start", 1, 50);
        begin
            bit seq [4];
            seq = '{1'b1, 1'b0, 1'b0, 1'b1};
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                m_ready = seq[i];
            end
        end
        wait_drain("t3_drain", 50);
        chk("t3_nbeats", 32'(bdata.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_data", (bdata.size() > i) ? 32'(bdata[i]) : 32'hFFFF_FFFF, 32'(8'h10 + i));
            chk("t3_id",   (bid.size() > i) ? 32'(bid[i]) : 32'hFFFF_FFFF, 32'd1);
        end
        chk("t3_ptr", 32'(dut.ptr), 32'd2);

        // input 3 granted, then 0 and 1 request: wrap to 0, then 1
        clear_q();
        cfg(3, 1, 3, 1, 8'h30);
        wait_id_valid("t4_start", 3, 50);
        cfg(0, 1, 2, 1, 8'h00);
        cfg(1, 1, 2, 1, 8'h50);
        wait_drain("t4_drain", 100);
        chk("t4_npkts", 32'(lasts.size()), 32'd3);
        e1 = '{3, 0, 1, 0, 0};
        for (int i = 0; i < 3; i++)
            chk("t4_order", (lasts.size() > i) ? 32'(lasts[i]) : 32'hFFFF_FFFF, 32'(e1[i]));
        chk("t4_ptr", 32'(dut.ptr), 32'd2);

        // reset for one cycle mid-packet on input 2
        clear_q();
        cfg(2, 1, 4, 1, 8'h80);
        k = 0;
        while (bid.size() < 2 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        chk("t5_start", 32'(k < 50), 32'd1);
        rstn = 1'b0;
        en[2] = 1'b0;
        pkts[2] = 0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_m_valid", 32'(m_valid), 32'd0);
        chk("t5_ptr",     32'(dut.ptr), 32'd0);
        chk("t5_state",   32'(dut.state), 32'd0);
        chk("t5_s_ready", 32'(s_ready), 32'd0);
        chk("t5_no_last", 32'(lasts.size()), 32'd0);
        #1 rstn = 1'b1;
        clear_q();
        cfg(1, 1, 1, 1, 8'h33);
        wait_drain("t5_drain", 50);
        chk("t5_after_id",   (lasts.size() > 0) ? 32'(lasts[0]) : 32'hFFFF_FFFF, 32'd1);
        chk("t5_after_data", (bdata.size() > 0) ? 32'(bdata[0]) : 32'hFFFF_FFFF, 32'h33);

`ifdef AXIS_ARB_PRIO0_EN
        // input 0 strict priority over input 2
        clear_q();
        cfg(0, 1, 2, 3, 8'h00);
        cfg(2, 1, 2, 1, 8'h90);
        wait_drain("t6_drain", 100);
        e1 = '{0, 0, 0, 2, 0};
        chk("t6_npkts", 32'(lasts.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("t6_order", (lasts.size() > i) ? 32'(lasts[i]) : 32'hFFFF_FFFF, 32'(e1[i]));
        chk("t6_ptr", 32'(dut.ptr), 32'd3);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
